accu_run_top: RTL and testbench



---
 rtl/accu_pkg.sv | 19 +
 rtl/press_qualifier.sv | 57 +++++
 rtl/accu_run_top.sv | 96 +++++++++
 tb/tb_accu_run_top.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/accu_pkg.sv
// Shared definitions for the accumulator run detector.
//   state_t     : FSM state encoding shown on state_display
//   STATE_W     : width of the state encoding
//   NEXT_S_RST  : reset value of the synchronised press input. It resets high,
//                 so a button held through reset reads as still pressed.
package accu_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    HIT  = 3'd2,
    LOCK = 3'd4
  } state_t;

  localparam logic NEXT_S_RST = 1'b1;

endpackage

// File: rtl/press_qualifier.sv
// Press qualifier: turns a raw button into a single-cycle accept pulse.
//   clk, reset : system clock, synchronous active-high reset
//   next       : raw button input (asynchronous)
//   in         : raw data bit (asynchronous)
//   accept     : one-cycle pulse, once per qualified high period
//   sample_bit : synchronised data bit to be used with accept
//   next_s     : synchronised button level (used by the FSM to leave LOCK)
module press_qualifier
  import accu_pkg::*;
#(
  parameter int DEB_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic next,
  input  logic in,
  output logic accept,
  output logic sample_bit,
  output logic next_s
);

  localparam int HI_W = $clog2(DEB_CYCLES + 1);
  localparam logic [HI_W-1:0] HI_MAX = HI_W'(DEB_CYCLES);
  localparam logic [HI_W-1:0] HI_ARM = HI_W'(DEB_CYCLES - 1);

  logic            next_s_reg;
  logic            in_s_reg;
  logic [HI_W-1:0] hi_cnt_reg;
  logic            armed_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      next_s_reg <= NEXT_S_RST;
      in_s_reg   <= 1'b0;
      hi_cnt_reg <= '0;
      armed_reg  <= 1'b0;
    end else begin
      next_s_reg <= next;
      in_s_reg   <= in;
      if (!next_s_reg) begin
        hi_cnt_reg <= '0;
        armed_reg  <= 1'b1;
      end else if (hi_cnt_reg != HI_MAX) begin
        // Saturating at DEB_CYCLES means the HI_ARM value is passed exactly
        // once per high period, giving a single accept however long the hold.
        hi_cnt_reg <= hi_cnt_reg + 1'b1;
      end
    end
  end

  // armed stays low after reset until a release is seen, so a button held
  // through reset cannot be accepted.
  assign accept     = next_s_reg && (hi_cnt_reg == HI_ARM) && armed_reg;
  assign sample_bit = in_s_reg;
  assign next_s     = next_s_reg;

endmodule

// File: rtl/accu_run_top.sv
// Serial run detector: counts consecutive ones on accepted presses and
// reports a hit when the run reaches RUN_LEN.
//   clk, reset    : system clock, synchronous active-high reset
//   next, in      : raw button and data bit
//   mode          : 0 = non-overlapping, 1 = overlapping (sampled on accept)
//   out           : registered, high while in HIT
//   state_display : FSM state encoding
//   run_cnt       : current run length
//   hit_count     : number of hits, wraps
module accu_run_top
  import accu_pkg::*;
#(
  parameter int RUN_LEN    = 3,
  parameter int RUN_W      = 4,
  parameter int DEB_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  input  logic               in,
  input  logic               mode,
  output logic               out,
  output logic [STATE_W-1:0] state_display,
  output logic [RUN_W-1:0]   run_cnt,
  output logic [CNT_W-1:0]   hit_count
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

  logic accept;
  logic sample_bit;
  logic next_s;

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [CNT_W-1:0] hit_reg, hit_next;
  logic             out_reg;

  press_qualifier #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_press_qualifier (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .in        (in),
    .accept    (accept),
    .sample_bit(sample_bit),
    .next_s    (next_s)
  );

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    hit_next   = hit_reg;
    if (state_reg == LOCK) begin
      if (!next_s) begin
        state_next = IDLE;
      end
    end else if (accept) begin
      if (!sample_bit) begin
        run_next   = '0;
        state_next = IDLE;
      end else if (run_reg >= RUN_MAX - 1'b1) begin
        // min(run+1, RUN_LEN) == RUN_LEN; in overlapping mode the run stays
        // full so every further one is another hit.
        run_next   = mode ? RUN_MAX : '0;
        hit_next   = hit_reg + 1'b1;
        state_next = HIT;
      end else begin
        run_next   = run_reg + 1'b1;
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= LOCK;
      run_reg   <= '0;
      hit_reg   <= '0;
      out_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      hit_reg   <= hit_next;
      out_reg   <= (state_next == HIT);
    end
  end

  assign out           = out_reg;
  assign state_display = state_reg;
  assign run_cnt       = run_reg;
  assign hit_count     = hit_reg;

endmodule

// File: tb/tb_accu_run_top.sv
module tb_accu_run_top;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic next = 1'b0;
  logic in = 1'b0;
  logic mode = 1'b0;

  logic       out_a;
  logic [2:0] st_a;
  logic [3:0] run_a;
  logic [7:0] hits_a;

  logic       out_w;
  logic [2:0] st_w;
  logic [3:0] run_w;
  logic [1:0] hits_w;

  int n_cmp = 0;
  int n_bad = 0;

  // press-level reference model for the default instance (RUN_LEN = 3)
  localparam int M_RUN_LEN = 3;
  int m_run, m_hits, m_state;

  always #10 clk = ~clk;

  accu_run_top dut (
    .clk(clk), .reset(reset), .next(next), .in(in), .mode(mode),
    .out(out_a), .state_display(st_a), .run_cnt(run_a), .hit_count(hits_a)
  );

  accu_run_top #(.RUN_LEN(1), .RUN_W(4), .DEB_CYCLES(2), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .next(next), .in(in), .mode(mode),
    .out(out_w), .state_display(st_w), .run_cnt(run_w), .hit_count(hits_w)
  );

  task automatic model_reset();
    m_run = 0; m_hits = 0; m_state = 0;
  endtask

  task automatic model_press(input bit b, input bit md);
    if (!b) begin
      m_run = 0; m_state = 0;
    end else if (((m_run + 1 < M_RUN_LEN) ? m_run + 1 : M_RUN_LEN) == M_RUN_LEN) begin
      m_hits  = (m_hits + 1) % 256;
      m_run   = md ? M_RUN_LEN : 0;
      m_state = 2;
    end else begin
      m_run = m_run + 1; m_state = 1;
    end
  endtask

  task automatic drive_press(input bit b, input bit md, input int hold);
    @(negedge clk);
    in = b; mode = md; next = 1'b1;
    repeat (hold) @(negedge clk);
    next = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    next = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    next = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (st_a !== 3'd4) begin n_bad++; $display("FAIL reset_state_during got=%0d want=4", st_a); end
    n_cmp++; if (out_a !== 1'b0) begin n_bad++; $display("FAIL reset_out_during got=%0b want=0", out_a); end
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (run_a !== 4'd0) begin n_bad++; $display("FAIL reset_run got=%0d want=0", run_a); end
    n_cmp++; if (hits_a !== 8'd0) begin n_bad++; $display("FAIL reset_hits got=%0d want=0", hits_a); end
    @(negedge clk);
    n_cmp++; if (st_a !== 3'd4) begin n_bad++; $display("FAIL reset_state_after got=%0d want=4", st_a); end
    @(negedge clk);
    n_cmp++; if (st_a !== 3'd0) begin n_bad++; $display("FAIL reset_to_idle got=%0d want=0", st_a); end
    n_cmp++; if (st_w !== 3'd0) begin n_bad++; $display("FAIL reset_to_idle_w got=%0d want=0", st_w); end
    model_reset();
  endtask

  task automatic test_sequence(input bit md);
    bit seq [12] = '{1,0,0,1,0,1,0,1,1,1,1,1};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive_press(seq[i], md, 2);
      model_press(seq[i], md);
      $display("seq mode=%0b press=%0d bit=%0b out=%0b state=%0d run=%0d hits=%0d",
               md, i + 1, seq[i], out_a, st_a, run_a, hits_a);
      n_cmp++; if (out_a !== (m_state == 2)) begin n_bad++; $display("FAIL seq_out p%0d got=%0b want=%0b", i + 1, out_a, m_state == 2); end
      n_cmp++; if (st_a !== 3'(m_state)) begin n_bad++; $display("FAIL seq_state p%0d got=%0d want=%0d", i + 1, st_a, m_state); end
      n_cmp++; if (run_a !== 4'(m_run)) begin n_bad++; $display("FAIL seq_run p%0d got=%0d want=%0d", i + 1, run_a, m_run); end
      n_cmp++; if (hits_a !== 8'(m_hits)) begin n_bad++; $display("FAIL seq_hits p%0d got=%0d want=%0d", i + 1, hits_a, m_hits); end
    end
    n_cmp++; if (hits_a !== (md ? 8'd3 : 8'd1)) begin n_bad++; $display("FAIL seq_final_hits got=%0d want=%0d", hits_a, md ? 3 : 1); end
  endtask

  task automatic test_debounce();
    do_reset();
    @(negedge clk);
    in = 1'b1; next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    repeat (6) @(negedge clk);
    $display("glitch state=%0d run=%0d hits=%0d", st_a, run_a, hits_a);
    n_cmp++; if (st_a !== 3'd0) begin n_bad++; $display("FAIL glitch_state got=%0d want=0", st_a); end
    n_cmp++; if (run_a !== 4'd0) begin n_bad++; $display("FAIL glitch_run got=%0d want=0", run_a); end
    drive_press(1'b1, 1'b0, 100);
    model_press(1'b1, 1'b0);
    $display("long_hold state=%0d run=%0d hits=%0d", st_a, run_a, hits_a);
    n_cmp++; if (run_a !== 4'(m_run)) begin n_bad++; $display("FAIL hold_run got=%0d want=%0d", run_a, m_run); end
    n_cmp++; if (hits_a !== 8'(m_hits)) begin n_bad++; $display("FAIL hold_hits got=%0d want=%0d", hits_a, m_hits); end
    n_cmp++; if (st_a !== 3'(m_state)) begin n_bad++; $display("FAIL hold_state got=%0d want=%0d", st_a, m_state); end
  endtask

  task automatic test_reset_held();
    do_reset();
    drive_press(1'b1, 1'b0, 2);
    @(negedge clk);
    in = 1'b1; next = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    $display("held_after_reset state=%0d run=%0d hits=%0d", st_a, run_a, hits_a);
    n_cmp++; if (st_a !== 3'd4) begin n_bad++; $display("FAIL held_lock got=%0d want=4", st_a); end
    n_cmp++; if (run_a !== 4'd0) begin n_bad++; $display("FAIL held_run got=%0d want=0", run_a); end
    next = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (st_a !== 3'd0) begin n_bad++; $display("FAIL release_idle got=%0d want=0", st_a); end
    model_reset();
    drive_press(1'b1, 1'b0, 2);
    model_press(1'b1, 1'b0);
    $display("repress state=%0d run=%0d", st_a, run_a);
    n_cmp++; if (st_a !== 3'(m_state)) begin n_bad++; $display("FAIL repress_state got=%0d want=%0d", st_a, m_state); end
    n_cmp++; if (run_a !== 4'(m_run)) begin n_bad++; $display("FAIL repress_run got=%0d want=%0d", run_a, m_run); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      bit b, md;
      int hold;
      b = ($urandom_range(0, 3) != 0);
      md = $urandom_range(0, 1);
      hold = $urandom_range(2, 5);
      drive_press(b, md, hold);
      model_press(b, md);
      $display("rand press=%0d bit=%0b mode=%0b state=%0d run=%0d hits=%0d", i, b, md, st_a, run_a, hits_a);
      n_cmp++; if (st_a !== 3'(m_state)) begin n_bad++; $display("FAIL rand_state p%0d got=%0d want=%0d", i, st_a, m_state); end
      n_cmp++; if (run_a !== 4'(m_run)) begin n_bad++; $display("FAIL rand_run p%0d got=%0d want=%0d", i, run_a, m_run); end
      n_cmp++; if (hits_a !== 8'(m_hits)) begin n_bad++; $display("FAIL rand_hits p%0d got=%0d want=%0d", i, hits_a, m_hits); end
      n_cmp++; if (out_a !== (m_state == 2)) begin n_bad++; $display("FAIL rand_out p%0d got=%0b want=%0b", i, out_a, m_state == 2); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive_press(1'b1, 1'b1, 2);
      $display("wrap press=%0d out=%0b state=%0d hits=%0d", k + 1, out_w, st_w, hits_w);
      n_cmp++; if (hits_w !== 2'((k + 1) % 4)) begin n_bad++; $display("FAIL wrap_hits p%0d got=%0d want=%0d", k + 1, hits_w, (k + 1) % 4); end
      n_cmp++; if (out_w !== 1'b1) begin n_bad++; $display("FAIL wrap_out p%0d got=%0b want=1", k + 1, out_w); end
      n_cmp++; if (st_w !== 3'd2) begin n_bad++; $display("FAIL wrap_state p%0d got=%0d want=2", k + 1, st_w); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequence(1'b0);
    test_sequence(1'b1);
    test_debounce();
    test_reset_held();
    test_random();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
